// File: rtl/digital_to_analog_stick_if.sv
// digital_to_analog_stick_if: direction/mode inputs and emulated X/Y outputs of the analog stick
// master drives PV, LF, RG, UP, DW, MODE, CENTER and reads AX, AY, ACTIVE; slave is the converter
interface digital_to_analog_stick_if #(
   parameter int W  = 8,
   parameter int VW = 9
);
   logic [VW-1:0] PV;
   logic          LF;
   logic          RG;
   logic          UP;
   logic          DW;
   logic          MODE;
   logic          CENTER;
   logic [W-1:0]  AX;
   logic [W-1:0]  AY;
   logic          ACTIVE;
   modport master (output PV, LF, RG, UP, DW, MODE, CENTER, input AX, AY, ACTIVE);
   modport slave  (input PV, LF, RG, UP, DW, MODE, CENTER, output AX, AY, ACTIVE);
endinterface

// File: rtl/digital_to_analog_stick.sv
// digital_to_analog_stick: turns held direction keys into an accelerating emulated analog X/Y position
// CLK pixel clock, RESET sync active-high; bus carries PV tick counter, LF/RG/UP/DW keys,
// MODE (0 spring, 1 hold), CENTER recentre, and registered AX/AY positions plus ACTIVE
module digital_to_analog_stick #(
   parameter int W         = 8,
   parameter int VW        = 9,
   parameter int TICK_LINE = 0,
   parameter int DELT_MIN  = 4,
   parameter int DELT_MAX  = 16,
   parameter int ACC       = 4,
   parameter int RET       = 15,
   parameter int LIM       = 120
) (
   input logic                  CLK,
   input logic                  RESET,
   digital_to_analog_stick_if.slave bus
);
   localparam int CTR = 2 ** (W - 1) - 1;
   localparam logic [VW-1:0]     TL    = TICK_LINE[VW-1:0];
   localparam logic signed [W+1:0] S_MIN = DELT_MIN[W+1:0];
   localparam logic signed [W+1:0] S_MAX = DELT_MAX[W+1:0];
   localparam logic signed [W+1:0] S_ACC = ACC[W+1:0];
   localparam logic signed [W+1:0] S_RET = RET[W+1:0];
   localparam logic signed [W+1:0] S_LIM = LIM[W+1:0];
   localparam logic signed [W+1:0] S_CTR = CTR[W+1:0];
   logic [VW-1:0] ppv;
   logic          tick;
   logic [1:0]    pos_in, neg_in;
   assign tick   = (bus.PV != ppv) && (bus.PV == TL);
   assign pos_in = {bus.UP, bus.LF};
   assign neg_in = {bus.DW, bus.RG};
   // axis 0 is X (LF/RG), axis 1 is Y (UP/DW); dir encoding 00 none, 01 positive, 10 negative
   for (genvar a = 0; a < 2; a++) begin : ax_g
      logic signed [W+1:0] acc, acc_n, step, step_n, use_s, sum, lim_s, rel, out_w;
      logic [1:0]          dir, dir_n, d;
      logic                held;
      logic [W-1:0]        q;
      always_comb begin
         held   = pos_in[a] ^ neg_in[a];
         d      = !held ? 2'b00 : pos_in[a] ? 2'b01 : 2'b10;
         use_s  = (d == dir) ? step : S_MIN;
         sum    = d[0] ? acc + use_s : acc - use_s;
         lim_s  = sum > S_LIM ? S_LIM : sum < -S_LIM ? -S_LIM : sum;
         // spring return snaps to zero once within one RET step so it never overshoots
         rel    = bus.MODE ? acc : acc > S_RET ? acc - S_RET : acc < -S_RET ? acc + S_RET : '0;
         acc_n  = bus.CENTER ? '0 : !tick ? acc : held ? lim_s : rel;
         step_n = (bus.CENTER || (tick && !held)) ? S_MIN : !tick ? step :
                  (use_s + S_ACC > S_MAX) ? S_MAX : use_s + S_ACC;
         dir_n  = bus.CENTER ? 2'b00 : tick ? d : dir;
         out_w  = acc_n + S_CTR;
      end
      always_ff @(posedge CLK) begin
         if (RESET) begin
            acc  <= '0;
            step <= S_MIN;
            dir  <= 2'b00;
            q    <= S_CTR[W-1:0];
         end else begin
            acc  <= acc_n;
            step <= step_n;
            dir  <= dir_n;
            q    <= out_w[W-1:0];
         end
      end
   end
   assign bus.AX = ax_g[0].q;
   assign bus.AY = ax_g[1].q;
   always_ff @(posedge CLK) begin
      if (RESET) begin
         ppv        <= '0;
         bus.ACTIVE <= 1'b0;
      end else begin
         ppv        <= bus.PV;
         bus.ACTIVE <= (ax_g[0].acc_n != '0) || (ax_g[1].acc_n != '0);
      end
   end
endmodule

// File: tb/tb_digital_to_analog_stick.sv
// tb_digital_to_analog_stick: per-cycle model comparison plus directed literal checks of the stick converter
module tb_digital_to_analog_stick;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;
   bit   run = 1'b0;
   int   macc [2];
   int   mstep [2];
   int   mdir [2];
   int   mppv;
   digital_to_analog_stick_if #(.W(8), .VW(9)) bus ();
   digital_to_analog_stick dut (.CLK(clk), .RESET(rst), .bus(bus));
   always #5 clk = ~clk;

   function automatic int clampi(int v);
      return v > 120 ? 120 : v < -120 ? -120 : v;
   endfunction

   // model: one update per frame tick, using signed integer position and step
   initial begin
      mppv = 0;
      for (int a = 0; a < 2; a++) begin
         macc[a] = 0; mstep[a] = 4; mdir[a] = 0;
      end
      forever begin
         @(posedge clk);
         if (rst) begin
            mppv = 0;
            for (int a = 0; a < 2; a++) begin
               macc[a] = 0; mstep[a] = 4; mdir[a] = 0;
            end
         end else begin
            bit mt;
            mt = (int'(bus.PV) != mppv) && (bus.PV == 0);
            mppv = int'(bus.PV);
            for (int a = 0; a < 2; a++) begin
               bit p, n;
               p = a ? bus.UP : bus.LF;
               n = a ? bus.DW : bus.RG;
               if (bus.CENTER) begin
                  macc[a] = 0; mstep[a] = 4; mdir[a] = 0;
               end else if (mt) begin
                  if (p != n) begin
                     int want, s;
                     want = p ? 1 : -1;
                     s = (want == mdir[a]) ? mstep[a] : 4;
                     macc[a] = clampi(macc[a] + want * s);
                     mstep[a] = (s + 4 > 16) ? 16 : s + 4;
                     mdir[a] = want;
                  end else begin
                     mdir[a] = 0; mstep[a] = 4;
                     if (!bus.MODE) begin
                        if (macc[a] <= 15 && macc[a] >= -15) macc[a] = 0;
                        else macc[a] = macc[a] > 0 ? macc[a] - 15 : macc[a] + 15;
                     end
                  end
               end
            end
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (run) begin
         n_cmp += 3;
         if (int'(bus.AX) != macc[0] + 127) begin
            n_err++; $display("FAIL model_ax t=%0t got %0d want %0d", $time, bus.AX, macc[0] + 127);
         end
         if (int'(bus.AY) != macc[1] + 127) begin
            n_err++; $display("FAIL model_ay t=%0t got %0d want %0d", $time, bus.AY, macc[1] + 127);
         end
         if (bus.ACTIVE != ((macc[0] != 0) || (macc[1] != 0))) begin
            n_err++; $display("FAIL model_active t=%0t got %0d want %0d", $time, bus.ACTIVE, (macc[0] != 0) || (macc[1] != 0));
         end
      end
   end

   task automatic chk(string name, int got, int want);
      n_cmp++;
      if (got != want) begin
         n_err++; $display("FAIL %s got %0d want %0d", name, got, want);
      end
   endtask

   task automatic tick_n(int n);
      repeat (n) begin
         @(negedge clk) bus.PV = 9'd1;
         @(negedge clk) bus.PV = 9'd0;
         @(negedge clk);
      end
   endtask

   initial begin
      int ax_seq [6] = '{131, 139, 151, 167, 183, 199};
      int ax_cont [4] = '{215, 231, 247, 247};
      bus.PV = '0; bus.LF = 0; bus.RG = 0; bus.UP = 0; bus.DW = 0; bus.MODE = 0; bus.CENTER = 0;
      @(negedge clk);
      run = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      bus.LF = 1;
      repeat (4) @(negedge clk);
      chk("reset_ax", int'(bus.AX), 127);
      chk("reset_ay", int'(bus.AY), 127);
      chk("reset_active", int'(bus.ACTIVE), 0);
      for (int i = 0; i < 6; i++) begin
         tick_n(1);
         chk($sformatf("ramp_ax%0d", i), int'(bus.AX), ax_seq[i]);
      end
      chk("ramp_ay", int'(bus.AY), 127);
      chk("ramp_active", int'(bus.ACTIVE), 1);
      for (int i = 0; i < 4; i++) begin
         tick_n(1);
         chk($sformatf("clamp_ax%0d", i), int'(bus.AX), ax_cont[i]);
      end
      bus.LF = 0; bus.RG = 1;
      tick_n(1);
      chk("reverse_ax", int'(bus.AX), 243);
      bus.CENTER = 1;
      @(negedge clk) bus.CENTER = 0;
      chk("center_ax", int'(bus.AX), 127);
      chk("center_active", int'(bus.ACTIVE), 0);
      bus.RG = 0; bus.LF = 1;
      tick_n(3);
      chk("build24_ax", int'(bus.AX), 151);
      bus.LF = 0; bus.RG = 1;
      tick_n(1);
      chk("build20_ax", int'(bus.AX), 147);
      bus.RG = 0;
      tick_n(1);
      chk("spring1_ax", int'(bus.AX), 132);
      chk("spring1_active", int'(bus.ACTIVE), 1);
      tick_n(1);
      chk("spring2_ax", int'(bus.AX), 127);
      chk("spring2_active", int'(bus.ACTIVE), 0);
      bus.MODE = 1; bus.DW = 1;
      tick_n(4);
      chk("hold_build_ay", int'(bus.AY), 87);
      bus.DW = 0;
      tick_n(5);
      chk("hold_keep_ay", int'(bus.AY), 87);
      bus.DW = 1;
      bus.PV = 9'd1;
      @(negedge clk) begin bus.PV = 9'd0; bus.CENTER = 1; end
      @(negedge clk);
      chk("center_tick_ay", int'(bus.AY), 127);
      bus.CENTER = 0; bus.DW = 0; bus.MODE = 0;
      bus.LF = 1; bus.RG = 1;
      tick_n(3);
      chk("cancel_ax", int'(bus.AX), 127);
      chk("cancel_active", int'(bus.ACTIVE), 0);
      bus.RG = 0;
      tick_n(6);
      chk("preset_ax", int'(bus.AX), 199);
      rst = 1'b1;
      @(negedge clk) rst = 1'b0;
      chk("midreset_ax", int'(bus.AX), 127);
      chk("midreset_active", int'(bus.ACTIVE), 0);
      tick_n(1);
      chk("post_reset_ax", int'(bus.AX), 131);
      run = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/digital_to_analog_stick.md
Name: digital_to_analog_stick

Overview:
- Generalised successor to the fixed-step pseudo-analog stick: converts four digital direction inputs per stick into an emulated analog X/Y position for analog-input arcade cores (e.g. the Food Fight AX/AY inputs).
- Adds parametrised output width, step size, limit and update line.
- Adds hold-on-release acceleration, selectable spring/hold release mode, opposite-direction cancel, non-overshooting return, and explicit recentre.
- Sits in the emu top level between keyboard/joystick merge logic and the game core, clocked by the pixel clock and ticked once per frame from the vertical counter.

Parameters:
W, 8, output width in bits per axis
VW, 9, width of PV input
TICK_LINE, 0, PV value whose arrival produces one update tick
DELT_MIN, 4, initial step per tick when a direction is first held
DELT_MAX, 16, maximum step per tick
ACC, 4, step increment per consecutive held tick
RET, 15, return-to-centre step per tick in spring mode
LIM, 120, magnitude clamp; constraint LIM <= 2^(W-1)-1

Ports:
CLK  in  1  pixel clock; all state on rising edge
RESET  in  1  synchronous, active-high reset
PV  in  VW  vertical position counter
LF  in  1  left held; drives X positive
RG  in  1  right held; drives X negative
UP  in  1  up held; drives Y positive
DW  in  1  down held; drives Y negative
MODE  in  1  0 = spring (return to centre on release), 1 = hold (keep position)
CENTER  in  1  level; zero both axes
AX  out  W  X position, centre = 2^(W-1)-1
AY  out  W  Y position, centre = 2^(W-1)-1
ACTIVE  out  1  1 when either accumulator is non-zero

Behaviour:
- Reset values: pPV=0; accumulators X=Y=0; stepX=stepY=DELT_MIN; dirX=dirY=none; AX=AY=2^(W-1)-1 (127 at W=8); ACTIVE=0.
- Reset dominates all other inputs in the same cycle. Reset mid-ramp discards all state.
- Tick:
  - tick = (PV != pPV) && (PV == TICK_LINE); pPV <= PV every cycle.
  - PV sitting at TICK_LINE gives exactly one tick.
  - Because pPV resets to 0, PV==0 during reset produces no tick on release of reset.
- Per axis (independent; X uses LF/RG, Y uses UP/DW), evaluated only on a tick:
  - Effective direction: pos only -> +; neg only -> -; both or neither -> released. Both pressed = cancel, not priority.
  - Held, same direction as previous tick: acc += ±step, then step <= min(step+ACC, DELT_MAX).
  - Held, new direction (from released or reversed): step used = DELT_MIN, then step <= min(DELT_MIN+ACC, DELT_MAX).
  - Released, MODE=0: if |acc| <= RET then acc <= 0, else acc moves RET toward 0. Never overshoots zero.
  - Released, MODE=1: acc unchanged.
  - Any release resets step to DELT_MIN and dir to none.
  - Clamp after add: acc = max(-LIM, min(LIM, acc)).
  - Accumulator is signed, width W+2, so there is no intermediate overflow.
- CENTER=1: both acc <= 0, steps <= DELT_MIN, dirs <= none. Overrides a coincident tick. Applies every cycle it is held.
- Outputs:
  - Registered; AX = acc_x + 2^(W-1)-1 and AY likewise, truncated to W bits (always in range by the LIM constraint).
  - Outputs update on the same edge as the accumulator, so they are visible the cycle after the tick condition is sampled.
  - ACTIVE is registered with the same timing.
- Direction inputs are sampled only at the tick edge; changes between ticks have no effect.

Test Plan (defaults, W=8):
1. RESET high 2 cycles with PV=0, then PV held 0 -> AX=AY=127, ACTIVE=0, no tick until PV leaves 0 and returns.
2. LF held, 6 ticks (PV cycling 0..N) -> AX = 131, 139, 151, 167, 183, 199 (steps 4, 8, 12, 16, 16, 16); AY=127; ACTIVE=1.
3. Continue LF 4 more ticks -> AX = 215, 231, 247, 247 (clamped at +120). Then RG for 1 tick -> step restarts at 4 -> AX=243.
4. MODE=0, X acc=20 (AX=147), release -> next ticks AX=132 then 127 (no overshoot); ACTIVE falls with AX=127.
5. MODE=1, acc_y=-40 (AY=87), release for 5 ticks -> AY stays 87. Assert CENTER on a tick edge with DW held -> AY=127 next cycle, tick ignored.
6. LF and RG both held for 3 ticks from acc 0, MODE=0 -> AX stays 127. Assert RESET mid-ramp at AX=199 -> AX=127 next cycle, and the next LF tick steps by 4 (AX=131).
